// File: rtl/period_meter.sv
// period_meter
//   Measures the period of an asynchronous input si in units of CLK_PER_UNIT
//   clocks, averaged over 2**LOG_AVG consecutive periods. The edge polarity
//   is selectable. Includes an input synchroniser, a saturation/overflow
//   flag, a no-edge timeout and a synchronous abort.
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   start        begin a measurement (sampled only in IDLE)
//   abort        synchronous cancel back to IDLE, no ticks
//   edge_sel     0 = rising edges, 1 = falling edges (sampled at start)
//   si           asynchronous measured signal
//   ready        high in IDLE only
//   done_tick    one-cycle pulse; prd/ovf valid this cycle
//   timeout_tick one-cycle pulse on timeout abort
//   ovf          last result saturated; cleared on accepted start
//   prd          averaged period in units; holds until next done
module period_meter #(
    parameter int unsigned CLK_PER_UNIT  = 50000,
    parameter int unsigned PRD_W         = 10,
    parameter int unsigned LOG_AVG       = 2,
    parameter int unsigned TIMEOUT_UNITS = 1023,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             edge_sel,
    input  logic             si,
    output logic             ready,
    output logic             done_tick,
    output logic             timeout_tick,
    output logic             ovf,
    output logic [PRD_W-1:0] prd
);

    localparam int unsigned T_W   = $clog2(CLK_PER_UNIT);
    localparam int unsigned ACC_W = PRD_W + LOG_AVG;
    localparam int unsigned N_W   = (LOG_AVG > 0) ? LOG_AVG : 1;
    localparam int unsigned TO_W  = (TIMEOUT_UNITS > 0) ? $clog2(TIMEOUT_UNITS + 1) : 1;

    localparam logic [T_W-1:0]  T_LAST   = T_W'(CLK_PER_UNIT - 1);
    localparam logic [T_W-1:0]  T_ONE    = T_W'(1);
    localparam logic [N_W-1:0]  N_LAST   = N_W'((1 << LOG_AVG) - 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_UNITS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_TOUT  = 3'd4;

    logic [2:0]             state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   dly;
    logic                   pol;
    logic [T_W-1:0]         t;
    logic [T_W-1:0]         t_next;
    logic [ACC_W-1:0]       acc;
    logic [N_W-1:0]         n;
    logic [TO_W-1:0]        to_cnt;
    logic                   sync_out;
    logic                   qual_edge;
    logic                   wrap;
    logic                   timeout_hit;

    // Input synchroniser followed by one delay flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            dly  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], si};
            dly  <= sync_out;
        end
    end

    assign sync_out    = sync[SYNC_STAGES-1];
    assign qual_edge   = pol ? (~sync_out & dly) : (sync_out & ~dly);
    assign wrap        = (t == T_LAST);
    assign t_next      = wrap ? '0 : t + T_ONE;
    assign timeout_hit = (TIMEOUT_UNITS != 0) && (to_cnt == TO_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            pol    <= 1'b0;
            t      <= '0;
            acc    <= '0;
            n      <= '0;
            to_cnt <= '0;
            ovf    <= 1'b0;
            prd    <= '0;
        end else if (abort && (state != S_IDLE)) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_ARM;
                        pol    <= edge_sel;
                        ovf    <= 1'b0;
                        t      <= '0;
                        to_cnt <= '0;
                    end
                end
                S_ARM: begin
                    if (qual_edge) begin
                        state  <= S_COUNT;
                        // The cycle the arming edge is seen counts as the
                        // first clock of the first unit, so the final sum
                        // is floor(total_clocks / CLK_PER_UNIT).
                        t      <= T_ONE;
                        acc    <= '0;
                        n      <= '0;
                        to_cnt <= '0;
                    end else if (wrap && timeout_hit) begin
                        state <= S_TOUT;
                    end else begin
                        t <= t_next;
                        if (wrap)
                            to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_COUNT: begin
                    t <= t_next;
                    if (qual_edge && (n == N_LAST)) begin
                        // Final edge: a coincident wrap is not accumulated.
                        state <= S_DONE;
                        prd   <= PRD_W'(acc >> LOG_AVG);
                    end else if (wrap && timeout_hit) begin
                        state <= S_TOUT;
                    end else begin
                        if (wrap) begin
                            if (acc == '1)
                                ovf <= 1'b1;
                            else
                                acc <= acc + ACC_W'(1);
                        end
                        if (qual_edge) begin
                            n      <= n + N_W'(1);
                            to_cnt <= '0;
                        end else if (wrap) begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_TOUT:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready        = (state == S_IDLE);
    assign done_tick    = (state == S_DONE);
    assign timeout_tick = (state == S_TOUT);

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
//   Self-checking bench for period_meter. Instance dut uses a 20-unit
//   timeout; instance dut_b has the timeout disabled so that long periods
//   can drive the accumulator into saturation. Expected results come from
//   a plain arithmetic model: sum of the averaged periods in clocks,
//   divided by CLK_PER_UNIT, clamped to the accumulator range, shifted
//   down by LOG_AVG.
module tb_period_meter;

    localparam int unsigned CPU = 4;
    localparam int unsigned PW  = 6;
    localparam int unsigned LA  = 2;
    localparam int unsigned TO  = 20;
    localparam int unsigned SS  = 2;
    localparam int unsigned NP  = 1 << LA;
    localparam int unsigned ACC_MAX = (1 << (PW + LA)) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          start_b = 1'b0;
    logic          abort = 1'b0;
    logic          edge_sel = 1'b0;
    logic          si = 1'b0;
    logic          ready, done_tick, timeout_tick, ovf;
    logic [PW-1:0] prd;
    logic          ready_b, done_tick_b, timeout_tick_b, ovf_b;
    logic [PW-1:0] prd_b;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned done_cnt = 0, tout_cnt = 0, done_cnt_b = 0, tout_cnt_b = 0;
    int unsigned per [NP];
    int unsigned last_prd = 0;

    always #5 clk = ~clk;

    period_meter #(
        .CLK_PER_UNIT(CPU), .PRD_W(PW), .LOG_AVG(LA),
        .TIMEOUT_UNITS(TO), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .edge_sel(edge_sel), .si(si), .ready(ready), .done_tick(done_tick),
        .timeout_tick(timeout_tick), .ovf(ovf), .prd(prd)
    );

    period_meter #(
        .CLK_PER_UNIT(CPU), .PRD_W(PW), .LOG_AVG(LA),
        .TIMEOUT_UNITS(0), .SYNC_STAGES(SS)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort),
        .edge_sel(edge_sel), .si(si), .ready(ready_b), .done_tick(done_tick_b),
        .timeout_tick(timeout_tick_b), .ovf(ovf_b), .prd(prd_b)
    );

    always @(negedge clk) begin
        if (done_tick)      done_cnt++;
        if (timeout_tick)   tout_cnt++;
        if (done_tick_b)    done_cnt_b++;
        if (timeout_tick_b) tout_cnt_b++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full measurement on either instance using the periods in per[].
    task automatic measure(input string tag, input logic mode, input bit poke, input bit use_b);
        int unsigned total, units, lat, d0, exp_prd;
        logic        exp_ovf;
        si = mode;
        repeat (6) tick();
        d0 = use_b ? done_cnt_b : done_cnt;
        edge_sel = mode;
        if (use_b) start_b = 1'b1; else start = 1'b1;
        tick();
        start = 1'b0;
        start_b = 1'b0;
        edge_sel = ~mode;
        repeat ($urandom_range(2, 6)) tick();
        check({tag, "_busy"}, use_b ? ready_b : ready, 0);
        total = 0;
        for (int k = 0; k < NP; k++) begin
            si = ~mode;
            repeat (per[k] / 2) tick();
            si = mode;
            if (poke && k == 1) start = 1'b1;
            tick();
            start = 1'b0;
            repeat (per[k] - per[k] / 2 - 1) tick();
            total += per[k];
        end
        si = ~mode;
        lat = 0;
        while (((use_b ? done_cnt_b : done_cnt) == d0) && lat < 12) begin
            tick();
            lat++;
        end
        units   = total / CPU;
        exp_ovf = (units > ACC_MAX);
        exp_prd = (exp_ovf ? ACC_MAX : units) >> LA;
        check({tag, "_lat"}, lat, SS + 1);
        check({tag, "_prd"}, use_b ? prd_b : prd, exp_prd);
        check({tag, "_ovf"}, use_b ? ovf_b : ovf, exp_ovf);
        repeat (3) tick();
        check({tag, "_ndone"}, (use_b ? done_cnt_b : done_cnt) - d0, 1);
        check({tag, "_ready"}, use_b ? ready_b : ready, 1);
        if (!use_b) last_prd = exp_prd;
    endtask

    initial begin
        int unsigned lat, t0, d0;

        repeat (3) tick();
        check("rst_ready", ready, 1);
        check("rst_prd", prd, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ticks", {30'd0, done_tick, timeout_tick}, 0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < NP; k++) per[k] = 40;
        measure("p40", 1'b0, 1'b1, 1'b0);

        per[0] = 36; per[1] = 40; per[2] = 44; per[3] = 48;
        measure("mix_rise", 1'b0, 1'b0, 1'b0);
        measure("mix_fall", 1'b1, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NP; k++) per[k] = $urandom_range(8, 64);
            measure("rnd", 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0);
        end

        // si held low: no qualifying edge ever arrives.
        si = 1'b0;
        edge_sel = 1'b0;
        repeat (4) tick();
        t0 = tout_cnt;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (tout_cnt == t0 && lat < 200) begin
            tick();
            lat++;
        end
        check("to_lat", lat - 1, CPU * (TO + 1));
        check("to_prd", prd, last_prd);
        tick();
        check("to_ready", ready, 1);
        check("to_count", tout_cnt - t0, 1);
        check("to_nodone", done_cnt - d0, 0);

        // Abort in COUNT.
        repeat (4) tick();
        t0 = tout_cnt;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            si = 1'b1; repeat (16) tick();
            si = 1'b0; repeat (16) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_ready", ready, 1);
        for (int k = 0; k < 3; k++) begin
            si = 1'b1; repeat (16) tick();
            si = 1'b0; repeat (16) tick();
        end
        repeat (100) tick();
        check("abort_ticks", (done_cnt - d0) + (tout_cnt - t0), 0);
        check("abort_prd", prd, last_prd);

        // Saturation on the instance without timeout.
        for (int k = 0; k < NP; k++) per[k] = 400;
        measure("sat", 1'b0, 1'b0, 1'b1);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("sat_ovf_clr", ovf_b, 0);
        check("sat_busy", ready_b, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("sat_abort_ready", ready_b, 1);
        check("sat_abort_prd", prd_b, 63);
        check("sat_no_tout", tout_cnt_b, 0);

        // Reset asserted in the middle of COUNT.
        si = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            si = 1'b1; repeat (12) tick();
            si = 1'b0; repeat (12) tick();
        end
        d0 = done_cnt;
        t0 = tout_cnt;
        reset = 1'b1;
        tick();
        check("mid_rst_ready", ready, 1);
        check("mid_rst_prd", prd, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_prd_b", prd_b, 0);
        reset = 1'b0;
        repeat (120) tick();
        check("mid_rst_ticks", (done_cnt - d0) + (tout_cnt - t0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
